// File: rtl/id_stage_pipe_if.sv
// ID stage bus: IF/ID inputs, writeback port, redirect and ID/EX outputs.
// Optional ID_PERF_CNT_EN adds the stall/bubble cycle counters.
interface id_stage_pipe_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
);
    logic              if_valid;
    logic [15:0]       instruction;
    logic [DATA_W-1:0] pc;
    logic [2:0]        flag;
    logic              flush;
    logic              wb_regwrite;
    logic [REG_AW-1:0] wb_dst;
    logic [DATA_W-1:0] wb_data;
    logic              stall;
    logic              redirect;
    logic [DATA_W-1:0] new_pc;
    logic              ex_valid;
    logic [8:0]        ex_ctrl;
    logic [REG_AW-1:0] ex_src1;
    logic [REG_AW-1:0] ex_src2;
    logic [REG_AW-1:0] ex_dst;
    logic [DATA_W-1:0] ex_data1;
    logic [DATA_W-1:0] ex_data2;
    logic [DATA_W-1:0] ex_imm;
    logic              halted;
`ifdef ID_PERF_CNT_EN
    logic [15:0]       stall_cycles;
    logic [15:0]       bubble_cycles;

    modport master (
        output if_valid, instruction, pc, flag, flush,
        output wb_regwrite, wb_dst, wb_data,
        input  stall, redirect, new_pc,
        input  ex_valid, ex_ctrl, ex_src1, ex_src2, ex_dst,
        input  ex_data1, ex_data2, ex_imm, halted,
        input  stall_cycles, bubble_cycles
    );

    modport slave (
        input  if_valid, instruction, pc, flag, flush,
        input  wb_regwrite, wb_dst, wb_data,
        output stall, redirect, new_pc,
        output ex_valid, ex_ctrl, ex_src1, ex_src2, ex_dst,
        output ex_data1, ex_data2, ex_imm, halted,
        output stall_cycles, bubble_cycles
    );
`else
    modport master (
        output if_valid, instruction, pc, flag, flush,
        output wb_regwrite, wb_dst, wb_data,
        input  stall, redirect, new_pc,
        input  ex_valid, ex_ctrl, ex_src1, ex_src2, ex_dst,
        input  ex_data1, ex_data2, ex_imm, halted
    );

    modport slave (
        input  if_valid, instruction, pc, flag, flush,
        input  wb_regwrite, wb_dst, wb_data,
        output stall, redirect, new_pc,
        output ex_valid, ex_ctrl, ex_src1, ex_src2, ex_dst,
        output ex_data1, ex_data2, ex_imm, halted
    );
`endif
endinterface

// File: rtl/id_stage_pipe.sv
// Decode stage with register file, load-use stall, halt FSM and ID/EX register.
// Define ID_PERF_CNT_EN to add saturating stall/bubble cycle counters.

module control_decoder (
    input  logic [3:0] opcode_i,
    output logic       regwrite_o,
    output logic       alusrc_o,
    output logic       memenable_o,
    output logic       memwrite_o,
    output logic       memtoreg_o,
    output logic [3:0] aluop_o,
    output logic       alusext_o,
    output logic       pcread_o,
    output logic [1:0] branch_o
);
    // Opcode to control lines; aluop passes the opcode through to EX
    always_comb begin
        regwrite_o  = 1'b0;
        alusrc_o    = 1'b0;
        memenable_o = 1'b0;
        memwrite_o  = 1'b0;
        memtoreg_o  = 1'b0;
        aluop_o     = opcode_i;
        alusext_o   = 1'b0;
        pcread_o    = 1'b0;
        branch_o    = 2'b00;
        case (opcode_i)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h7: begin
                regwrite_o = 1'b1;
            end
            4'h4, 4'h5, 4'h6: begin
                regwrite_o = 1'b1;
                alusrc_o   = 1'b1;
            end
            4'h8: begin
                regwrite_o  = 1'b1;
                alusrc_o    = 1'b1;
                memenable_o = 1'b1;
                memtoreg_o  = 1'b1;
            end
            4'h9: begin
                alusrc_o    = 1'b1;
                memenable_o = 1'b1;
                memwrite_o  = 1'b1;
            end
            4'hA, 4'hB: begin
                regwrite_o = 1'b1;
                alusrc_o   = 1'b1;
                alusext_o  = 1'b1;
            end
            4'hC: branch_o = 2'b01;
            4'hD: branch_o = 2'b10;
            4'hE: begin
                regwrite_o = 1'b1;
                pcread_o   = 1'b1;
            end
            4'hF: branch_o = 2'b11;
        endcase
    end
endmodule

module pc_control #(
    parameter int DATA_W = 16
) (
    input  logic [1:0]        branch_i,
    input  logic [2:0]        ccc_i,
    input  logic [2:0]        flag_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [8:0]        off_i,
    output logic              taken_o,
    output logic [DATA_W-1:0] target_o
);
    logic              z, v, n;
    logic              cond;
    logic [DATA_W-1:0] off_ext;

    assign {z, v, n} = flag_i;
    assign off_ext   = {{(DATA_W-9){off_i[8]}}, off_i} << 1;

    // Condition codes shared by B and BR
    always_comb begin
        cond = 1'b0;
        case (ccc_i)
            3'b000: cond = !z;
            3'b001: cond = z;
            3'b010: cond = !z && !n;
            3'b011: cond = n;
            3'b100: cond = z || !n;
            3'b101: cond = n || z;
            3'b110: cond = v;
            3'b111: cond = 1'b1;
        endcase
    end

    assign taken_o  = (branch_i == 2'b01 || branch_i == 2'b10) && cond;
    assign target_o = (branch_i == 2'b10) ? rs_data_i : pc_i + off_ext;
endmodule

module id_stage_pipe #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
) (
    input  logic           clk,
    input  logic           rst,
    id_stage_pipe_if.slave bus
);
    localparam int NREGS = 1 << REG_AW;

    typedef enum logic [1:0] {
        S_RUN,
        S_STALL,
        S_HALTED
    } state_t;

    typedef struct packed {
        logic       regwrite;
        logic       alusrc;
        logic       memenable;
        logic       memwrite;
        logic       memtoreg;
        logic [3:0] aluop;
    } ctrl_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] rf_q [NREGS];

    logic              ex_valid_q, ex_valid_d;
    ctrl_t             ex_ctrl_q, ex_ctrl_d;
    logic [REG_AW-1:0] ex_src1_q, ex_src1_d;
    logic [REG_AW-1:0] ex_src2_q, ex_src2_d;
    logic [REG_AW-1:0] ex_dst_q, ex_dst_d;
    logic [DATA_W-1:0] ex_data1_q, ex_data1_d;
    logic [DATA_W-1:0] ex_data2_q, ex_data2_d;
    logic [DATA_W-1:0] ex_imm_q, ex_imm_d;

    logic              dec_regwrite, dec_alusrc, dec_memenable;
    logic              dec_memwrite, dec_memtoreg;
    logic [3:0]        dec_aluop;
    logic              dec_alusext, dec_pcread;
    logic [1:0]        dec_branch;
    ctrl_t             dec_ctrl;

    logic [REG_AW-1:0] f_rd, f_rs, f_rt;
    logic [REG_AW-1:0] src1, src2;
    logic [DATA_W-1:0] rdata1, rdata2, data1;
    logic [DATA_W-1:0] imm;
    logic              use1, use2;
    logic              ld_pending, hazard;
    logic              not_halted, stall, issue;
    logic              taken;
    logic [DATA_W-1:0] target;
    logic              hlt_issue;

    control_decoder u_dec (
        .opcode_i    (bus.instruction[15:12]),
        .regwrite_o  (dec_regwrite),
        .alusrc_o    (dec_alusrc),
        .memenable_o (dec_memenable),
        .memwrite_o  (dec_memwrite),
        .memtoreg_o  (dec_memtoreg),
        .aluop_o     (dec_aluop),
        .alusext_o   (dec_alusext),
        .pcread_o    (dec_pcread),
        .branch_o    (dec_branch)
    );

    assign dec_ctrl = {dec_regwrite, dec_alusrc, dec_memenable,
                       dec_memwrite, dec_memtoreg, dec_aluop};

    assign f_rd = REG_AW'(bus.instruction[11:8]);
    assign f_rs = REG_AW'(bus.instruction[7:4]);
    assign f_rt = REG_AW'(bus.instruction[3:0]);

    // Operand index selection; SW reads its store data through src2
    always_comb begin
        src1 = f_rs;
        if (dec_alusext) src1 = f_rd;
        if (dec_pcread)  src1 = '0;
        src2 = f_rt;
        if (dec_alusrc || dec_pcread) src2 = '0;
        if (dec_memwrite) src2 = f_rd;
    end

    // Which sources are architecturally read (B/HLT/PCS read nothing)
    assign use1 = !dec_pcread &&
                  (dec_branch == 2'b00 || dec_branch == 2'b10);
    assign use2 = (dec_branch == 2'b00) &&
                  (dec_memwrite || !(dec_alusrc || dec_pcread));

    // Register file; R0 is never written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else if (bus.wb_regwrite && bus.wb_dst != '0) begin
            rf_q[bus.wb_dst] <= bus.wb_data;
        end
    end

    // Port 1 read with write-through bypass
    always_comb begin
        rdata1 = rf_q[src1];
        if (bus.wb_regwrite && bus.wb_dst == src1) rdata1 = bus.wb_data;
        if (src1 == '0) rdata1 = '0;
    end

    // Port 2 read with write-through bypass
    always_comb begin
        rdata2 = rf_q[src2];
        if (bus.wb_regwrite && bus.wb_dst == src2) rdata2 = bus.wb_data;
        if (src2 == '0) rdata2 = '0;
    end

    assign data1 = dec_pcread ? bus.pc : rdata1;
    assign imm   = dec_alusext ? DATA_W'(bus.instruction[7:0])
                               : {{(DATA_W-4){bus.instruction[3]}},
                                  bus.instruction[3:0]};

    pc_control #(.DATA_W(DATA_W)) u_pcc (
        .branch_i  (dec_branch),
        .ccc_i     (bus.instruction[11:9]),
        .flag_i    (bus.flag),
        .pc_i      (bus.pc),
        .rs_data_i (data1),
        .off_i     (bus.instruction[8:0]),
        .taken_o   (taken),
        .target_o  (target)
    );

    assign ld_pending = ex_valid_q && ex_ctrl_q.memenable &&
                        !ex_ctrl_q.memwrite && ex_ctrl_q.regwrite &&
                        (ex_dst_q != '0);
    assign hazard     = bus.if_valid && ld_pending &&
                        ((use1 && ex_dst_q == src1) ||
                         (use2 && ex_dst_q == src2));
    assign not_halted = (state_q != S_HALTED);
    assign stall      = hazard && !bus.flush && not_halted;
    assign issue      = bus.if_valid && !stall && !bus.flush && not_halted;
    assign hlt_issue  = issue && (dec_branch == 2'b11);

    // Control FSM next state; HALTED only leaves on reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (hlt_issue)  state_d = S_HALTED;
                else if (stall) state_d = S_STALL;
            end
            S_STALL: begin
                if (hlt_issue) state_d = S_HALTED;
                else           state_d = S_RUN;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_RUN;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_RUN;
        else     state_q <= state_d;
    end

    // ID/EX next contents; a bubble clears valid and control only
    always_comb begin
        ex_valid_d = issue;
        ex_ctrl_d  = issue ? dec_ctrl : '0;
        ex_src1_d  = src1;
        ex_src2_d  = src2;
        ex_dst_d   = f_rd;
        ex_data1_d = data1;
        ex_data2_d = rdata2;
        ex_imm_d   = imm;
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
            ex_src1_q  <= '0;
            ex_src2_q  <= '0;
            ex_dst_q   <= '0;
            ex_data1_q <= '0;
            ex_data2_q <= '0;
            ex_imm_q   <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_ctrl_q  <= ex_ctrl_d;
            ex_src1_q  <= ex_src1_d;
            ex_src2_q  <= ex_src2_d;
            ex_dst_q   <= ex_dst_d;
            ex_data1_q <= ex_data1_d;
            ex_data2_q <= ex_data2_d;
            ex_imm_q   <= ex_imm_d;
        end
    end

    assign bus.stall    = stall;
    assign bus.redirect = taken && issue;
    assign bus.new_pc   = target;
    assign bus.ex_valid = ex_valid_q;
    assign bus.ex_ctrl  = ex_ctrl_q;
    assign bus.ex_src1  = ex_src1_q;
    assign bus.ex_src2  = ex_src2_q;
    assign bus.ex_dst   = ex_dst_q;
    assign bus.ex_data1 = ex_data1_q;
    assign bus.ex_data2 = ex_data2_q;
    assign bus.ex_imm   = ex_imm_q;
    assign bus.halted   = (state_q == S_HALTED);

`ifdef ID_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    // Saturating counters; halted cycles are not counted as bubbles
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (stall && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
        if (!issue && not_halted && bubble_cnt_q != 16'hFFFF)
            bubble_cnt_d = bubble_cnt_q + 16'd1;
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.stall_cycles  = stall_cnt_q;
    assign bus.bubble_cycles = bubble_cnt_q;
`endif
endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed vector bench for id_stage_pipe.
// Covers bypass, load-use stall, branches, flush priority, halt and reset.
module tb_id_stage_pipe;
    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    typedef struct {
        logic        iv;
        logic [15:0] ins;
        logic [15:0] pc;
        logic [2:0]  flag;
        logic        fl;
        logic        wbe;
        logic [3:0]  wbd;
        logic [15:0] wbdat;
        logic        e_stall;
        logic        e_redir;
        logic        c_npc;
        logic [15:0] e_npc;
        logic        e_ev;
        logic [8:0]  e_ctrl;
        logic        c_d;
        logic [15:0] e_d1;
        logic [15:0] e_d2;
        logic        c_imm;
        logic [15:0] e_imm;
        logic        e_halt;
    } vec_t;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    vec_t tbl [$];

    id_stage_pipe_if #(.DATA_W(16), .REG_AW(4)) bus ();

    id_stage_pipe #(.DATA_W(16), .REG_AW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bus.if_valid    = v.iv;
        bus.instruction = v.ins;
        bus.pc          = v.pc;
        bus.flag        = v.flag;
        bus.flush       = v.fl;
        bus.wb_regwrite = v.wbe;
        bus.wb_dst      = v.wbd;
        bus.wb_data     = v.wbdat;
        #3;
        chk($sformatf("v%0d stall", idx), 32'(bus.stall), 32'(v.e_stall));
        chk($sformatf("v%0d redirect", idx), 32'(bus.redirect),
            32'(v.e_redir));
        if (v.c_npc)
            chk($sformatf("v%0d new_pc", idx), 32'(bus.new_pc),
                32'(v.e_npc));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d ex_valid", idx), 32'(bus.ex_valid),
            32'(v.e_ev));
        chk($sformatf("v%0d ex_ctrl", idx), 32'(bus.ex_ctrl),
            32'(v.e_ctrl));
        chk($sformatf("v%0d halted", idx), 32'(bus.halted), 32'(v.e_halt));
        if (v.c_d) begin
            chk($sformatf("v%0d ex_data1", idx), 32'(bus.ex_data1),
                32'(v.e_d1));
            chk($sformatf("v%0d ex_data2", idx), 32'(bus.ex_data2),
                32'(v.e_d2));
        end
        if (v.c_imm)
            chk($sformatf("v%0d ex_imm", idx), 32'(bus.ex_imm),
                32'(v.e_imm));
        @(negedge clk);
    endtask

    initial begin
        int exp_bub;
        int exp_stl;
        vec_t rv;
        n_pass  = 0;
        n_total = 0;
        exp_bub = 0;
        exp_stl = 0;

        // 0: ADD R1,R3,R2 with R3 written this cycle (bypass)
        tbl.push_back('{Y,16'h0132,16'h0002,3'b000,N, Y,4'd3,16'h1234, N,N,N,16'h0000, Y,9'h100,Y,16'h1234,16'h0000,N,16'h0000,N});
        // 1: same ADD, R2 bypassed, R3 from file
        tbl.push_back('{Y,16'h0132,16'h0002,3'b000,N, Y,4'd2,16'h0005, N,N,N,16'h0000, Y,9'h100,Y,16'h1234,16'h0005,N,16'h0000,N});
        // 2: LW R4,[R2+0]
        tbl.push_back('{Y,16'h8420,16'h0004,3'b000,N, N,4'd0,16'h0000, N,N,N,16'h0000, Y,9'h1D8,Y,16'h0005,16'h0000,Y,16'h0000,N});
        // 3: ADD R5,R4,R4 load-use -> stall, bubble
        tbl.push_back('{Y,16'h0544,16'h0006,3'b000,N, N,4'd0,16'h0000, Y,N,N,16'h0000, N,9'h000,N,16'h0000,16'h0000,N,16'h0000,N});
        // 4: held ADD issues, R4 arrives via bypass
        tbl.push_back('{Y,16'h0544,16'h0006,3'b000,N, Y,4'd4,16'h0077, N,N,N,16'h0000, Y,9'h100,Y,16'h0077,16'h0077,N,16'h0000,N});
        // 5: B EQ +3 at pc 0x10 with Z set -> taken to 0x16
        tbl.push_back('{Y,16'hC203,16'h0010,3'b100,N, N,4'd0,16'h0000, N,Y,Y,16'h0016, Y,9'h00C,N,16'h0000,16'h0000,N,16'h0000,N});
        // 6: same branch, Z clear -> not taken
        tbl.push_back('{Y,16'hC203,16'h0010,3'b000,N, N,4'd0,16'h0000, N,N,N,16'h0000, Y,9'h00C,N,16'h0000,16'h0000,N,16'h0000,N});
        // 7: BR NEQ R3 -> target is R3
        tbl.push_back('{Y,16'hD030,16'h0012,3'b000,N, N,4'd0,16'h0000, N,Y,Y,16'h1234, Y,9'h00D,Y,16'h1234,16'h0000,N,16'h0000,N});
        // 8: LLB R6,0xAB zero-extended immediate
        tbl.push_back('{Y,16'hA6AB,16'h0014,3'b000,N, N,4'd0,16'h0000, N,N,N,16'h0000, Y,9'h18A,Y,16'h0000,16'h0000,Y,16'h00AB,N});
        // 9: PCS R7 reads pc as data1
        tbl.push_back('{Y,16'hE700,16'h0040,3'b000,N, N,4'd0,16'h0000, N,N,N,16'h0000, Y,9'h10E,Y,16'h0040,16'h0000,N,16'h0000,N});
        // 10: ADD R1,R0,R0 while writing R0 -> reads stay 0
        tbl.push_back('{Y,16'h0100,16'h0042,3'b000,N, Y,4'd0,16'hFFFF, N,N,N,16'h0000, Y,9'h100,Y,16'h0000,16'h0000,N,16'h0000,N});
        // 11: LW R4,[R2+0]
        tbl.push_back('{Y,16'h8420,16'h0044,3'b000,N, N,4'd0,16'h0000, N,N,N,16'h0000, Y,9'h1D8,Y,16'h0005,16'h0000,N,16'h0000,N});
        // 12: hazard with flush -> no stall, bubble
        tbl.push_back('{Y,16'h0544,16'h0046,3'b000,Y, N,4'd0,16'h0000, N,N,N,16'h0000, N,9'h000,N,16'h0000,16'h0000,N,16'h0000,N});
        // 13: LW R4,[R2+0]
        tbl.push_back('{Y,16'h8420,16'h0048,3'b000,N, N,4'd0,16'h0000, N,N,N,16'h0000, Y,9'h1D8,Y,16'h0005,16'h0000,N,16'h0000,N});
        // 14: BR NEQ R4 load-use -> stall, redirect suppressed
        tbl.push_back('{Y,16'hD040,16'h004A,3'b000,N, N,4'd0,16'h0000, Y,N,N,16'h0000, N,9'h000,N,16'h0000,16'h0000,N,16'h0000,N});
        // 15: BR issues with R4 bypassed -> redirect to 0x100
        tbl.push_back('{Y,16'hD040,16'h004A,3'b000,N, Y,4'd4,16'h0100, N,Y,Y,16'h0100, Y,9'h00D,Y,16'h0100,16'h0000,N,16'h0000,N});
        // 16: HLT with flush -> not issued, not halted
        tbl.push_back('{Y,16'hF000,16'h004C,3'b000,Y, N,4'd0,16'h0000, N,N,N,16'h0000, N,9'h000,N,16'h0000,16'h0000,N,16'h0000,N});
        // 17: idle slot -> bubble
        tbl.push_back('{N,16'h0000,16'h004E,3'b000,N, N,4'd0,16'h0000, N,N,N,16'h0000, N,9'h000,N,16'h0000,16'h0000,N,16'h0000,N});
        // 18: ADD still issues (still running)
        tbl.push_back('{Y,16'h0132,16'h0050,3'b000,N, N,4'd0,16'h0000, N,N,N,16'h0000, Y,9'h100,Y,16'h1234,16'h0005,N,16'h0000,N});
        // 19: HLT issues -> halted
        tbl.push_back('{Y,16'hF000,16'h0052,3'b000,N, N,4'd0,16'h0000, N,N,N,16'h0000, Y,9'h00F,N,16'h0000,16'h0000,N,16'h0000,Y});
        // 20: halted, if_valid ignored
        tbl.push_back('{Y,16'h0132,16'h0054,3'b000,N, Y,4'd8,16'h0BEE, N,N,N,16'h0000, N,9'h000,N,16'h0000,16'h0000,N,16'h0000,Y});
        // 21: halted, taken branch gives no redirect
        tbl.push_back('{Y,16'hC203,16'h0010,3'b100,N, N,4'd0,16'h0000, N,N,N,16'h0000, N,9'h000,N,16'h0000,16'h0000,N,16'h0000,Y});
        // 22: halted, load gives no issue
        tbl.push_back('{Y,16'h8420,16'h0056,3'b000,N, N,4'd0,16'h0000, N,N,N,16'h0000, N,9'h000,N,16'h0000,16'h0000,N,16'h0000,Y});

        rst             = 1'b1;
        bus.if_valid    = 1'b0;
        bus.instruction = 16'h0000;
        bus.pc          = 16'h0000;
        bus.flag        = 3'b000;
        bus.flush       = 1'b0;
        bus.wb_regwrite = 1'b0;
        bus.wb_dst      = 4'd0;
        bus.wb_data     = 16'h0000;
        repeat (2) @(negedge clk);
        chk("reset ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("reset ex_ctrl", 32'(bus.ex_ctrl), 32'd0);
        chk("reset halted", 32'(bus.halted), 32'd0);
        chk("reset stall", 32'(bus.stall), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], i);
            if (!tbl[i].e_ev && !tbl[i].e_halt) exp_bub++;
            if (tbl[i].e_stall) exp_stl++;
        end

`ifdef ID_PERF_CNT_EN
        chk("perf stall_cycles", 32'(bus.stall_cycles), 32'(exp_stl));
        chk("perf bubble_cycles", 32'(bus.bubble_cycles), 32'(exp_bub));
`endif

        // Asynchronous reset between edges while halted
        #2;
        rst = 1'b1;
        #1;
        chk("async rst ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("async rst ex_ctrl", 32'(bus.ex_ctrl), 32'd0);
        chk("async rst halted", 32'(bus.halted), 32'd0);
`ifdef ID_PERF_CNT_EN
        chk("async rst stall_cycles", 32'(bus.stall_cycles), 32'd0);
        chk("async rst bubble_cycles", 32'(bus.bubble_cycles), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // After reset: running again, register file cleared
        rv = '{Y,16'h0132,16'h0002,3'b000,N, N,4'd0,16'h0000, N,N,N,16'h0000, Y,9'h100,Y,16'h0000,16'h0000,N,16'h0000,N};
        run_vec(rv, 100);
        rv = '{Y,16'hA6AB,16'h0004,3'b000,N, N,4'd0,16'h0000, N,N,N,16'h0000, Y,9'h18A,Y,16'h0000,16'h0000,Y,16'h00AB,N};
        run_vec(rv, 101);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
